// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between the rx sequencer, its shift register and the byte consumer
//   rx          serial line into the sequencer (idle high)
//   sr_q        external shift register contents
//   sr_enable   shift-register enable pulse
//   sr_d        synchronised rx, feeds the shift register d input
//   data        last received byte
//   data_valid  one-cycle frame-decoded pulse
//   parity_err  qualifies data_valid: parity mismatch
//   frame_err   qualifies data_valid: stop bit was 0
//   busy        sequencer not idle
//   master = environment side, slave = sequencer side
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    localparam int WORD_LENGTH = DATA_BITS + 3;
    logic                   rx;
    logic [WORD_LENGTH-1:0] sr_q;
    logic                   sr_enable;
    logic                   sr_d;
    logic [DATA_BITS-1:0]   data;
    logic                   data_valid;
    logic                   parity_err;
    logic                   frame_err;
    logic                   busy;
    modport master (
        output rx, sr_q,
        input  sr_enable, sr_d, data, data_valid, parity_err, frame_err, busy
    );
    modport slave (
        input  rx, sr_q,
        output sr_enable, sr_d, data, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive sequencer driving an external 11-bit serial-in shift register
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    uart_rx_if.slave: rx/sr_q in; sr_enable, sr_d, data, data_valid,
//          parity_err, frame_err, busy out
// Frame: start(0), DATA_BITS data LSB first, even parity, stop(1).
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input logic     clk,
    input logic     reset,
    uart_rx_if.slave bus
);
    localparam int WORD_LENGTH = DATA_BITS + 3;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, CHECK, WAIT_HIGH} state_t;

    state_t                 state_q;
    logic                   rx_meta_q, rx_s_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bitcnt_q;
    logic                   sr_en_q, dv_q, pe_q, fe_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [WORD_LENGTH-1:0] frame_d;
    logic [DATA_BITS-1:0]   data_d;
    logic                   sr_msb_unused;

    // CHECK coincides with the last enable pulse, so the decode looks at the
    // value the register is about to capture: sr_q shifted once more by sr_d.
    assign frame_d       = {bus.sr_q[WORD_LENGTH-2:0], rx_s_q};
    assign sr_msb_unused = bus.sr_q[WORD_LENGTH-1];

    for (genvar i = 0; i < DATA_BITS; i++) begin : g_data
        assign data_d[i] = frame_d[WORD_LENGTH-2-i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            sr_en_q   <= 1'b0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            sr_en_q   <= 1'b0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    cnt_q   <= '0;
                    state_q <= START;
                end
                START: if (cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
                    if (rx_s_q) state_q <= IDLE;
                    else begin
                        sr_en_q  <= 1'b1;
                        bitcnt_q <= BW'(1);
                        cnt_q    <= '0;
                        state_q  <= SHIFT;
                    end
                end else cnt_q <= cnt_q + 1'b1;
                SHIFT: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    sr_en_q  <= 1'b1;
                    bitcnt_q <= bitcnt_q + 1'b1;
                    cnt_q    <= '0;
                    if (bitcnt_q == BW'(WORD_LENGTH - 1)) state_q <= CHECK;
                end else cnt_q <= cnt_q + 1'b1;
                CHECK: begin
                    data_q  <= data_d;
                    dv_q    <= 1'b1;
                    pe_q    <= ^{data_d, frame_d[1]};
                    fe_q    <= ~frame_d[0];
                    state_q <= frame_d[0] ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sr_enable  = sr_en_q;
    assign bus.sr_d       = rx_s_q;
    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a behavioural 11-bit shift register
module tb_uart_rx_ctrl;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    int         n_en, n_dv, n_ovl, fall_cyc;
    int         en_t [0:31];
    int         dv_t [0:3];
    logic [7:0] dv_d [0:3];
    logic       dv_pe, dv_fe, err_seen;
    logic       prev_sr_d = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) ifc ();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // external serial-in register: shifts sr_d in at the LSB on each enable
    always @(posedge clk) if (ifc.sr_enable) ifc.sr_q <= {ifc.sr_q[9:0], ifc.sr_d};

    always @(negedge clk) begin
        if (prev_sr_d === 1'b1 && ifc.sr_d === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
        prev_sr_d = ifc.sr_d;
        if (ifc.sr_enable) begin
            if (n_en < 32) en_t[n_en] = cyc;
            n_en++;
        end
        if (ifc.data_valid) begin
            if (n_dv < 4) begin
                dv_t[n_dv] = cyc;
                dv_d[n_dv] = ifc.data;
            end
            n_dv++;
            dv_pe = ifc.parity_err;
            dv_fe = ifc.frame_err;
            err_seen = err_seen | ifc.parity_err | ifc.frame_err;
        end
        if (ifc.sr_enable && ifc.data_valid) n_ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_en = 0; n_dv = 0; n_ovl = 0; fall_cyc = -1;
        dv_pe = 1'bx; dv_fe = 1'bx; err_seen = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // seq[0] goes out first (start bit)
    task automatic send_n(input logic [10:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            ifc.rx = seq[i];
            wait_n(CPB);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp);
        send_n({stp, par, d, 1'b0}, 11);
    endtask

    function automatic int bad_gaps(input int first);
        int b = 0;
        for (int i = first + 1; i < first + 11; i++) if (en_t[i] - en_t[i-1] != CPB) b++;
        return b;
    endfunction

    initial begin
        ifc.rx = 1'b1;
        clr();
        wait_n(3);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_dv", ifc.data_valid, 0);
        chk("rst_data", ifc.data, 0);
        chk("rst_en", ifc.sr_enable, 0);
        chk("rst_pe", ifc.parity_err, 0);
        chk("rst_fe", ifc.frame_err, 0);
        reset = 1'b1;
        wait_n(4);

        // T1: 0xA5 has four ones, parity 0
        clr();
        send(8'hA5, 1'b0, 1'b1);
        wait_n(8);
        chk("t1_en_count", n_en, 11);
        // one IDLE-detect cycle + 8 START counts: 8 whole cycles lie between fall and pulse
        chk("t1_first_en", en_t[0] - fall_cyc, 9);
        chk("t1_gaps", bad_gaps(0), 0);
        chk("t1_dv_count", n_dv, 1);
        chk("t1_dv_latency", dv_t[0] - en_t[10], 1);
        chk("t1_data", dv_d[0], 8'hA5);
        chk("t1_pe", dv_pe, 0);
        chk("t1_fe", dv_fe, 0);
        chk("t1_overlap", n_ovl, 0);
        chk("t1_data_held", ifc.data, 8'hA5);

        // T2: 4-cycle glitch is a false start
        clr();
        ifc.rx = 1'b0;
        wait_n(4);
        ifc.rx = 1'b1;
        wait_n(1);
        chk("t2_busy_mid", ifc.busy, 1);
        wait_n(11);
        chk("t2_busy_end", ifc.busy, 0);
        chk("t2_en_count", n_en, 0);
        chk("t2_dv_count", n_dv, 0);

        // T3: 0x01 needs parity 1, send 0
        clr();
        send(8'h01, 1'b0, 1'b1);
        wait_n(8);
        chk("t3_dv_count", n_dv, 1);
        chk("t3_data", dv_d[0], 8'h01);
        chk("t3_pe", dv_pe, 1);
        chk("t3_fe", dv_fe, 0);

        // T4: 0x55 with stop 0, line then held low
        clr();
        send(8'h55, 1'b0, 1'b0);
        wait_n(40 * CPB);
        chk("t4_dv_count", n_dv, 1);
        chk("t4_data", dv_d[0], 8'h55);
        chk("t4_pe", dv_pe, 0);
        chk("t4_fe", dv_fe, 1);
        chk("t4_busy_low", ifc.busy, 1);
        chk("t4_en_count", n_en, 11);
        ifc.rx = 1'b1;
        wait_n(8);
        chk("t4_busy_released", ifc.busy, 0);
        clr();
        send(8'h12, 1'b0, 1'b1);
        wait_n(8);
        chk("t4_next_dv", n_dv, 1);
        chk("t4_next_data", dv_d[0], 8'h12);
        chk("t4_next_err", err_seen, 0);

        // T5: reset asserted in the middle of data bit 4
        clr();
        send_n({1'b1, 1'b0, 8'h99, 1'b0}, 5);
        ifc.rx = 1'b1;
        wait_n(CPB / 2);
        chk("t5_busy_before", ifc.busy, 1);
        reset = 1'b0;
        #1;
        chk("t5_busy", ifc.busy, 0);
        chk("t5_dv", ifc.data_valid, 0);
        chk("t5_data", ifc.data, 0);
        wait_n(4);
        reset = 1'b1;
        wait_n(4);
        clr();
        send(8'h3C, 1'b0, 1'b1);
        wait_n(8);
        chk("t5_dv_count", n_dv, 1);
        chk("t5_data_after", dv_d[0], 8'h3C);
        chk("t5_err", err_seen, 0);

        // T6: 0x00 then 0xFF back to back
        clr();
        send(8'h00, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        wait_n(8);
        chk("t6_dv_count", n_dv, 2);
        chk("t6_dv_spacing", dv_t[1] - dv_t[0], 11 * CPB);
        chk("t6_data0", dv_d[0], 8'h00);
        chk("t6_data1", dv_d[1], 8'hFF);
        chk("t6_err", err_seen, 0);
        chk("t6_en_count", n_en, 22);
        chk("t6_gaps", bad_gaps(11), 0);
        chk("t6_overlap", n_ovl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
